ddr2_btm_traffic_gen: RTL and testbench

DDR2_BTM_TRAFFIC_GEN -- requirements
Module: ddr2_btm_traffic_gen

---
 rtl/ddr2_btm_traffic_gen.sv | 193 +++++++++++++++++++
 tb/tb_ddr2_btm_traffic_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_btm_traffic_gen.sv
// DDR2 bottom-side traffic generator: writes a known pattern to NUM_WORDS
// local words, reads them back, and reports pass/fail/timeout with
// miscompare statistics.
module ddr2_btm_traffic_gen #(
   parameter int NUM_WORDS = 256,
   parameter int TIMEOUT   = 4096
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         local_init_done,
   input  logic         local_ready,
   input  logic         local_rdata_valid,
   input  logic [127:0] local_rdata,
   output logic         local_write_req,
   output logic         local_read_req,
   output logic         local_burstbegin,
   output logic         local_size,
   output logic         local_autopch_req,
   output logic         local_cs_addr,
   output logic [12:0]  local_row_addr,
   output logic [1:0]   local_bank_addr,
   output logic [8:0]   local_col_addr,
   output logic [127:0] local_wdata,
   output logic [15:0]  local_be,
   output logic         busy,
   output logic         pass,
   output logic         fail,
   output logic         timeout,
   output logic [15:0]  err_count,
   output logic [22:0]  first_err_addr
);

   localparam logic [22:0] LAST_IDX = 23'(NUM_WORDS - 1);
   localparam logic [31:0] TO_LIM   = 32'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE} state_t;

   state_t      state, state_nxt;
   logic [22:0] req_idx, rd_cnt, ld_idx;
   logic [31:0] idle_cnt;
   logic        rd_phase, resp, miscmp, idle_hit, last_req, ld_en, run_start;

   // Four copies of {idx ^ A5C3, idx} in the low 16 bits of the word index.
   function automatic logic [127:0] pattern(input logic [22:0] idx);
      return {4{idx[15:0] ^ 16'hA5C3, idx[15:0]}};
   endfunction

   assign local_size        = 1'b1;
   assign local_autopch_req = 1'b0;
   assign local_cs_addr     = 1'b0;
   assign local_be          = '1;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state plus the request-register load strobe and the index to load.
   always_comb begin
      state_nxt = state;
      ld_en     = 1'b0;
      ld_idx    = req_idx;
      run_start = 1'b0;
      rd_phase  = (state == READ) || (state == DRAIN);
      resp      = rd_phase && local_rdata_valid;
      miscmp    = resp && (local_rdata != pattern(rd_cnt));
      idle_hit  = rd_phase && !local_rdata_valid && (idle_cnt + 32'd1 == TO_LIM);
      last_req  = (req_idx == LAST_IDX);
      case (state)
         IDLE, DONE: if (start) begin
            state_nxt = WAIT_INIT;
            run_start = 1'b1;
         end
         WAIT_INIT: if (local_init_done) state_nxt = WRITE;
         WRITE: begin
            // First WRITE cycle loads word 0; after that each acceptance loads
            // the next word, and the last one loads read address 0 directly.
            if (!local_write_req) begin
               ld_en = 1'b1;
            end else if (local_ready) begin
               ld_en  = 1'b1;
               ld_idx = last_req ? '0 : req_idx + 23'd1;
               if (last_req) state_nxt = READ;
            end
         end
         READ: begin
            if (local_ready && !last_req) begin
               ld_en  = 1'b1;
               ld_idx = req_idx + 23'd1;
            end
            if (idle_hit)                     state_nxt = DONE;
            else if (local_ready && last_req) state_nxt = DRAIN;
         end
         DRAIN: if (idle_hit || (resp && rd_cnt == LAST_IDX)) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered request outputs, response checking and run status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         local_write_req  <= 1'b0;
         local_read_req   <= 1'b0;
         local_burstbegin <= 1'b0;
         local_row_addr   <= '0;
         local_bank_addr  <= '0;
         local_col_addr   <= '0;
         local_wdata      <= '0;
         req_idx          <= '0;
         rd_cnt           <= '0;
         idle_cnt         <= '0;
         busy             <= 1'b0;
         pass             <= 1'b0;
         fail             <= 1'b0;
         timeout          <= 1'b0;
         err_count        <= '0;
         first_err_addr   <= '0;
      end else begin
         if (ld_en) begin
            local_row_addr  <= {1'b0, ld_idx[22:11]};
            local_bank_addr <= ld_idx[10:9];
            local_col_addr  <= ld_idx[8:0];
            local_wdata     <= pattern(ld_idx);
         end
         case (state)
            WRITE: begin
               if (!local_write_req) begin
                  local_write_req  <= 1'b1;
                  local_burstbegin <= 1'b1;
               end else if (local_ready) begin
                  req_idx <= ld_idx;
                  if (last_req) begin
                     local_write_req <= 1'b0;
                     local_read_req  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (local_ready) begin
                  if (last_req) begin
                     local_read_req   <= 1'b0;
                     local_burstbegin <= 1'b0;
                  end else begin
                     req_idx <= ld_idx;
                  end
               end
            end
            default: ;
         endcase
         if (run_start) begin
            req_idx        <= '0;
            rd_cnt         <= '0;
            idle_cnt       <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
         end
         if (rd_phase) begin
            if (resp) begin
               rd_cnt   <= rd_cnt + 23'd1;
               idle_cnt <= '0;
               if (miscmp) begin
                  if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                  if (err_count == 16'd0)    first_err_addr <= rd_cnt;
               end
            end else begin
               idle_cnt <= idle_cnt + 32'd1;
            end
         end
         // Entering DONE: drop any pending request (timeout in READ) and
         // settle the verdict, including a miscompare on the final word.
         if (state_nxt == DONE && state != DONE) begin
            busy             <= 1'b0;
            local_read_req   <= 1'b0;
            local_burstbegin <= 1'b0;
            if (idle_hit) begin
               timeout <= 1'b1;
               fail    <= 1'b1;
            end else if (err_count == 16'd0 && !miscmp) begin
               pass <= 1'b1;
            end else begin
               fail <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr2_btm_traffic_gen.sv
// Scoreboard bench for ddr2_btm_traffic_gen: a memory model answers the
// local port, a monitor checks every accepted request and each run verdict.
module tb_ddr2_btm_traffic_gen;
   localparam int NW  = 16;
   localparam int TO  = 64;
   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         reset, start, init_done, ready, rvalid;
   logic [127:0] rdata;
   logic         local_write_req, local_read_req, local_burstbegin, local_size;
   logic         local_autopch_req, local_cs_addr;
   logic [12:0]  local_row_addr;
   logic [1:0]   local_bank_addr;
   logic [8:0]   local_col_addr;
   logic [127:0] local_wdata;
   logic [15:0]  local_be;
   logic         busy, pass, fail, timeout;
   logic [15:0]  err_count;
   logic [22:0]  first_err_addr;

   ddr2_btm_traffic_gen #(.NUM_WORDS(NW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .local_init_done(init_done),
      .local_ready(ready), .local_rdata_valid(rvalid), .local_rdata(rdata),
      .local_write_req(local_write_req), .local_read_req(local_read_req),
      .local_burstbegin(local_burstbegin), .local_size(local_size),
      .local_autopch_req(local_autopch_req), .local_cs_addr(local_cs_addr),
      .local_row_addr(local_row_addr), .local_bank_addr(local_bank_addr),
      .local_col_addr(local_col_addr), .local_wdata(local_wdata),
      .local_be(local_be), .busy(busy), .pass(pass), .fail(fail),
      .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   typedef struct {bit wr; int idx;} req_t;
   typedef struct {bit p; bit f; bit t; int errs; int first; int delta;} stat_t;
   typedef struct {int due; int idx;} pend_t;

   req_t         exp_req[$];
   stat_t        exp_stat[$];
   pend_t        pend[$];
   logic [127:0] mem [0:NW-1];
   int           checks = 0, errors = 0, cyc = 0, last_valid_cyc = 0;
   bit           stall_mode = 1'b0;
   int           stall_left = 0, rd_issued = 0, drop_after = 1000;
   logic [NW-1:0] corrupt = '0;

   function automatic logic [127:0] pat(input int i);
      logic [15:0] l;
      l = 16'(i);
      return {4{l ^ 16'hA5C3, l}};
   endfunction

   // {cs, row, bank, col} expected for word index i.
   function automatic logic [24:0] addr_of(input int i);
      logic [22:0] v;
      v = 23'(i);
      return {1'b0, 1'b0, v[22:11], v[10:9], v[8:0]};
   endfunction

   function automatic int addr_idx();
      logic [22:0] v;
      v = {local_row_addr[11:0], local_bank_addr, local_col_addr};
      return int'(v) % NW;
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: drives ready/rdata for the coming edge.
   initial begin
      pend_t p;
      ready = 1'b0; rvalid = 1'b0; rdata = '0;
      forever begin
         @(negedge clk);
         if (stall_mode && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end else begin
            ready = 1'b1;
            if (stall_mode && (local_write_req || local_read_req)) stall_left = $urandom_range(0, 5);
         end
         if (ready && local_write_req) mem[addr_idx()] = local_wdata;
         else if (ready && local_read_req) begin
            if (rd_issued < drop_after) begin
               p.due = cyc + 1 + LAT;
               p.idx = addr_idx();
               pend.push_back(p);
            end
            rd_issued++;
         end
         rvalid = 1'b0;
         rdata  = '0;
         if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            p = pend.pop_front();
            rvalid = 1'b1;
            rdata  = mem[p.idx] ^ (corrupt[p.idx] ? 128'h1 : 128'h0);
            last_valid_cyc = cyc + 1;
         end
      end
   end

   // Monitor: accepted requests, hold-while-stalled, end-of-run verdicts.
   initial begin
      req_t         e;
      stat_t        s;
      logic [159:0] held;
      logic [127:0] w5;
      bit           armed, prev_busy;
      armed = 1'b0; prev_busy = 1'b0; held = '0;
      w5 = {4{16'hA5C6, 16'h0005}};
      forever begin
         @(negedge clk);
         #2;
         if (armed && !reset)
            chk("hold_stable", 160'({local_write_req, local_read_req, local_burstbegin, local_row_addr,
                local_bank_addr, local_col_addr, local_wdata}), held);
         armed = 1'b0;
         if (!reset && (local_write_req || local_read_req)) begin
            if (!ready) begin
               held = 160'({local_write_req, local_read_req, local_burstbegin, local_row_addr,
                      local_bank_addr, local_col_addr, local_wdata});
               armed = 1'b1;
            end else if (exp_req.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_req: got wr=%0b rd=%0b, expected none", local_write_req, local_read_req);
            end else begin
               e = exp_req.pop_front();
               chk("req_kind", 160'({local_write_req, local_read_req}), 160'({e.wr, !e.wr}));
               chk("req_addr", 160'({local_cs_addr, local_row_addr, local_bank_addr, local_col_addr}),
                   160'(addr_of(e.idx)));
               chk("burstbegin", 160'(local_burstbegin), 160'(1));
               if (e.wr) chk("wdata", 160'(local_wdata), 160'(pat(e.idx)));
               if (e.wr && e.idx == 5) chk("wdata_word5", 160'(local_wdata), 160'(w5));
            end
         end
         if (reset) prev_busy = 1'b0;
         else begin
            if (prev_busy && !busy) begin
               if (exp_stat.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got busy fall, expected none");
               end else begin
                  s = exp_stat.pop_front();
                  chk("pass", 160'(pass), 160'(s.p));
                  chk("fail", 160'(fail), 160'(s.f));
                  chk("timeout", 160'(timeout), 160'(s.t));
                  chk("err_count", 160'(err_count), 160'(s.errs));
                  chk("first_err_addr", 160'(first_err_addr), 160'(s.first));
                  if (s.delta != 0) chk("done_delay", 160'(cyc - last_valid_cyc), 160'(s.delta));
               end
            end
            prev_busy = busy;
         end
      end
   end

   task automatic start_run(input int errs, input int first, input bit p, input bit f,
                            input bit t, input int delta);
      req_t  r;
      stat_t s;
      for (int i = 0; i < NW; i++) begin r.wr = 1'b1; r.idx = i; exp_req.push_back(r); end
      for (int i = 0; i < NW; i++) begin r.wr = 1'b0; r.idx = i; exp_req.push_back(r); end
      s.p = p; s.f = f; s.t = t; s.errs = errs; s.first = first; s.delta = delta;
      exp_stat.push_back(s);
      rd_issued = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      if (busy !== 1'b0) begin
         checks++; errors++;
         $display("FAIL %s_done: got busy=%0b after %0d cycles, expected 0", name, busy, n);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      int n;
      reset = 1'b1; start = 1'b0; init_done = 1'b1;
      #12;
      chk("rst_strobes", 160'({local_write_req, local_read_req, local_burstbegin}), 160'(0));
      chk("rst_addr", 160'({local_cs_addr, local_row_addr, local_bank_addr, local_col_addr}), 160'(0));
      chk("rst_wdata", 160'(local_wdata), 160'(0));
      chk("rst_status", 160'({busy, pass, fail, timeout}), 160'(0));
      chk("rst_err_count", 160'(err_count), 160'(0));
      chk("rst_first_err", 160'(first_err_addr), 160'(0));
      chk("const_size", 160'(local_size), 160'(1));
      chk("const_be", 160'(local_be), 160'(16'hFFFF));
      chk("const_autopch", 160'(local_autopch_req), 160'(0));
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);

      // Clean back-to-back run; a start pulse mid-run must be ignored.
      start_run(0, 0, 1'b1, 1'b0, 1'b0, 0);
      repeat (25) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done("clean");

      // Random stalls plus a dip of init_done during the run.
      stall_mode = 1'b1;
      start_run(0, 0, 1'b1, 1'b0, 1'b0, 0);
      repeat (10) @(negedge clk);
      init_done = 1'b0;
      repeat (20) @(negedge clk);
      init_done = 1'b1;
      wait_done("stall");
      stall_mode = 1'b0;

      // Corrupted read data at indices 3 and 9.
      corrupt = '0; corrupt[3] = 1'b1; corrupt[9] = 1'b1;
      start_run(2, 3, 1'b0, 1'b1, 1'b0, 0);
      wait_done("corrupt");
      corrupt = '0;

      // Memory stops answering after 10 reads.
      drop_after = 10;
      start_run(0, 0, 1'b0, 1'b1, 1'b1, TO);
      wait_done("timeout");
      drop_after = 1000;

      // Calibration late: no requests while init_done is low.
      init_done = 1'b0;
      start_run(0, 0, 1'b1, 1'b0, 1'b0, 0);
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (local_write_req || local_read_req || busy !== 1'b1) bad = 1'b1;
      end
      chk("init_low_quiet", 160'(bad), 160'(0));
      init_done = 1'b1;
      wait_done("init");

      // Reset during READ, then a fresh run.
      start_run(0, 0, 1'b1, 1'b0, 1'b0, 0);
      n = 0;
      while (local_read_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("reach_read", 160'(local_read_req), 160'(1));
      repeat (3) @(negedge clk);
      #3 reset = 1'b1;
      #1;
      chk("midrun_rst_strobes", 160'({local_write_req, local_read_req, local_burstbegin}), 160'(0));
      chk("midrun_rst_busy", 160'(busy), 160'(0));
      exp_req.delete();
      exp_stat.delete();
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_ignores_rdata", 160'({err_count, busy, pass, fail}), 160'(0));
      start_run(0, 0, 1'b1, 1'b0, 1'b0, 0);
      wait_done("after_reset");

      chk("req_queue_empty", 160'(exp_req.size()), 160'(0));
      chk("stat_queue_empty", 160'(exp_stat.size()), 160'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
